lcd_write_engine: RTL and testbench
===================================

// Module: lcd_write_engine
// PURPOSE
//   Downstream stage between the Nios/Qsys byte source and the HD44780 character LCD pins (en/rw/rs/db).
//   Accepts one byte per valid/ready handshake and generates HD44780-compliant write cycles in hardware.
//   Cycle timing covers address setup, E pulse width, hold, and per-command execution wait.
//   Runs the power-up init sequence itself, so software only pushes commands and characters.
// PARAMETERS
//   SETUP_CYC     4        cycles rs/db stable before lcd_en rises (>=40 ns @50 MHz)
//   EN_HIGH_CYC   12       cycles lcd_en held high (>=230 ns)
//   HOLD_CYC      2        cycles rs/db held after lcd_en falls
//   CMD_WAIT_CYC  2000     execution wait after normal command/data (40 us)
//   CLR_WAIT_CYC  80000    execution wait after clear (0x01) / return-home (0x02/0x03), rs=0 (1.6 ms)
//   PWR_WAIT_CYC  1000000  delay after reset release before first init write (20 ms)
//   INIT_EN       1        1: run init sequence after reset; 0: go directly to IDLE
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   cmd_valid  in   1  upstream has a byte; must hold cmd_rs/cmd_data stable until accepted
//   cmd_ready  out  1  engine idle; transfer occurs on clk edge with cmd_valid&&cmd_ready
//   cmd_rs     in   1  0 = instruction, 1 = data (character)
//   cmd_data   in   8  byte to write
//   init_done  out  1  init sequence complete (sticky until reset)
//   busy       out  1  ~cmd_ready
//   lcd_en     out  1  HD44780 E strobe
//   lcd_rw     out  1  HD44780 R/W; constant 0 (write-only)
//   lcd_rs     out  1  HD44780 RS
//   lcd_db     out  8  HD44780 DB7..DB0
// BEHAVIOUR
//   Reset (async, immediate):
//     lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_db=8'h00, cmd_ready=0, init_done=0; state=PWR_WAIT, counter cleared.
//   All outputs are registered; no combinational path from inputs to lcd_* pins.
//   State machine:
//     PWR_WAIT  count PWR_WAIT_CYC cycles -> INIT (INIT_EN=1) or IDLE with init_done=1 (INIT_EN=0).
//       With INIT_EN=0, cmd_ready rises 1 cycle after rst_n release.
//     INIT      load next ROM entry (rs=0): 38,38,38,0C,01,06 -> SETUP; after 6th entry's WAIT -> IDLE, init_done=1.
//     IDLE      cmd_ready=1; on handshake latch cmd_rs/cmd_data into lcd_rs/lcd_db -> SETUP next cycle.
//     SETUP     lcd_en=0 for SETUP_CYC cycles -> EN_HI.
//     EN_HI     lcd_en=1 for EN_HIGH_CYC cycles -> HOLD.
//     HOLD      lcd_en=0 for HOLD_CYC cycles; lcd_rs/lcd_db unchanged -> WAIT.
//     WAIT      lcd_en=0 for CLR_WAIT_CYC if (rs==0 && db[7:2]==0 && db[1:0]!=0), else CMD_WAIT_CYC -> INIT or IDLE.
//   lcd_rs/lcd_db change only on the cycle entering SETUP; otherwise stable (they keep the last byte in IDLE).
//   Latency: cmd_ready reasserts exactly SETUP+EN_HIGH+HOLD+WAIT+1 cycles after the accepting edge.
//   cmd_ready stays 0 during PWR_WAIT/INIT; upstream cmd_valid is not consumed then (no drop, no queue).
//   Back-to-back: valid held high is accepted on the first IDLE cycle; one byte per handshake, never duplicated.
//   Counter is wide enough for max(all *_CYC) via $clog2; every *_CYC parameter must be >=1.
//   rst_n asserted mid-pulse: lcd_en drops at once; on release the full PWR_WAIT + init sequence repeats.
// TESTING  (bench params: SETUP=2, EN_HIGH=3, HOLD=1, CMD_WAIT=5, CLR_WAIT=20, PWR_WAIT=10)
//   1. Release rst_n -> lcd_en low 10 cycles.
//      Then 6 E pulses of 3 cycles with rs=0, db=38,38,38,0C,01,06; gap after 0x01 is 20 cycles.
//      init_done and cmd_ready go 1 after the last wait.
//   2. After init, push rs=1 data=0x41 -> one 3-cycle E pulse, rs=1, db=0x41 stable from SETUP through HOLD.
//      cmd_ready returns 12 cycles after the handshake.
//   3. Push rs=0 0x01 -> 20-cycle wait; rs=1 0x01 -> 5-cycle wait; rs=0 0x80 -> 5-cycle wait.
//   4. Hold cmd_valid=1 and present 0x48,0x49,0x21 on successive handshakes -> exactly 3 E pulses in order.
//      No loss or duplication; no handshake while cmd_ready=0.
//   5. Drive rst_n low during the 2nd cycle of EN_HI -> lcd_en=0 with no clock edge needed; all outputs at reset values.
//      After release, init sequence replays from 0x38.
//   6. INIT_EN=0 -> cmd_ready=1 and init_done=1 one cycle after rst_n release; no E pulses until first command.

Source files
------------

// File: rtl/lcd_write_engine.sv
// HD44780 write engine: turns valid/ready byte transfers into timed E-strobe write cycles,
// and runs the power-up init sequence itself so software only pushes commands and characters.
module lcd_write_engine #(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_HIGH_CYC  = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 80000,
    parameter int unsigned PWR_WAIT_CYC = 1000000,
    parameter bit          INIT_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [7:0] lcd_db
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, CMD_WAIT_CYC)),
                                           max2(CLR_WAIT_CYC, PWR_WAIT_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [2:0]       ROM_LEN    = 3'd6;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       rom_idx, rom_idx_d;
    logic             en_d, rs_d, ready_d, done_d;
    logic [7:0]       db_d;
    logic             is_slow_cmd;
    logic [CNT_W-1:0] wait_last;

    // 8-bit interface, 2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    // Clear display and return home need the long execution wait.
    assign is_slow_cmd = !lcd_rs && (lcd_db[7:2] == 6'd0) && (lcd_db[1:0] != 2'd0);
    assign wait_last   = is_slow_cmd ? CLR_LAST : CMD_LAST;

    assign lcd_rw = 1'b0;
    assign busy   = ~cmd_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
        state_d   = state;
        cnt_d     = cnt;
        rom_idx_d = rom_idx;
        en_d      = lcd_en;
        rs_d      = lcd_rs;
        db_d      = lcd_db;
        ready_d   = cmd_ready;
        done_d    = init_done;

        case (state)
            S_PWR_WAIT: begin
                if (!INIT_EN) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else if (cnt == PWR_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_INIT: begin
                rs_d      = 1'b0;
                db_d      = init_byte(rom_idx);
                rom_idx_d = rom_idx + 3'd1;
                state_d   = S_SETUP;
                cnt_d     = '0;
            end
            S_IDLE: begin
                // First IDLE cycle arms the handshake; a transfer can only land once ready is visible.
                if (!cmd_ready) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else if (cmd_valid) begin
                    rs_d    = cmd_rs;
                    db_d    = cmd_data;
                    ready_d = 1'b0;
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_d = S_EN_HI;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_EN_HI: begin
                if (cnt == EN_LAST) begin
                    state_d = S_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == wait_last) begin
                    state_d = (!init_done && rom_idx != ROM_LEN) ? S_INIT : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWR_WAIT;
            cnt       <= '0;
            rom_idx   <= '0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= 8'h00;
            cmd_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rom_idx   <= rom_idx_d;
            lcd_en    <= en_d;
            lcd_rs    <= rs_d;
            lcd_db    <= db_d;
            cmd_ready <= ready_d;
            init_done <= done_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: per-cycle comparison against a schedule-based model of the
// HD44780 write timing, plus hand-computed latency and pulse-order checks.
module tb_lcd_write_engine;

    localparam int SETUP = 2, EN_HIGH = 3, HOLD = 1, CMD_WAIT = 5, CLR_WAIT = 20, PWR_WAIT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, init_done, busy, lcd_en, lcd_rw, lcd_rs;
    logic [7:0] lcd_db;

    logic       rst2_n = 1'b0;
    logic       valid2 = 1'b0, rs2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       ready2, done2, busy2, en2, rw2, lcd_rs2;
    logic [7:0] db2;

    int tests = 0, fails = 0;
    int cyc;

    always #5 clk = ~clk;

    lcd_write_engine #(.SETUP_CYC(SETUP), .EN_HIGH_CYC(EN_HIGH), .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMD_WAIT),
                       .CLR_WAIT_CYC(CLR_WAIT), .PWR_WAIT_CYC(PWR_WAIT), .INIT_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs),
        .cmd_data(cmd_data), .init_done(init_done), .busy(busy), .lcd_en(lcd_en), .lcd_rw(lcd_rw),
        .lcd_rs(lcd_rs), .lcd_db(lcd_db));

    lcd_write_engine #(.SETUP_CYC(SETUP), .EN_HIGH_CYC(EN_HIGH), .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMD_WAIT),
                       .CLR_WAIT_CYC(CLR_WAIT), .PWR_WAIT_CYC(PWR_WAIT), .INIT_EN(1'b0)) u_noinit (
        .clk(clk), .rst_n(rst2_n), .cmd_valid(valid2), .cmd_ready(ready2), .cmd_rs(rs2),
        .cmd_data(data2), .init_done(done2), .busy(busy2), .lcd_en(en2), .lcd_rw(rw2),
        .lcd_rs(lcd_rs2), .lcd_db(db2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Model: a queue of expected pin states, one per clock, built from the write-cycle rules.
    typedef struct packed {
        logic       en;
        logic       rs;
        logic [7:0] db;
        logic       ready;
        logic       done;
    } exp_t;

    exp_t exp_now;
    exp_t sched[$];
    logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic push_write(input logic rs, input logic [7:0] db, input logic done);
        int n_wait;
        exp_t e;
        n_wait = (!rs && db <= 8'h03 && db != 8'h00) ? CLR_WAIT : CMD_WAIT;
        e = '{en: 1'b0, rs: rs, db: db, ready: 1'b0, done: done};
        for (int i = 0; i < SETUP; i++) sched.push_back(e);
        e.en = 1'b1;
        for (int i = 0; i < EN_HIGH; i++) sched.push_back(e);
        e.en = 1'b0;
        for (int i = 0; i < HOLD + n_wait; i++) sched.push_back(e);
        sched.push_back(e);  // turnaround: next ROM fetch, or arming of ready
    endtask

    task automatic model_reset();
        exp_now = '0;
        sched.delete();
        // Power wait spans PWR_WAIT cycles counted from the release cycle; the last one fetches the first byte.
        for (int i = 0; i < PWR_WAIT; i++) sched.push_back('0);
        foreach (init_seq[i]) push_write(1'b0, init_seq[i], 1'b0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (sched.size() != 0) begin
            exp_now = sched.pop_front();
        end else if (exp_now.ready && cmd_valid) begin
            push_write(cmd_rs, cmd_data, 1'b1);
            exp_now = sched.pop_front();
        end else begin
            exp_now.en    = 1'b0;
            exp_now.ready = 1'b1;
            exp_now.done  = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check($sformatf("pins@cyc%0d {en,rw,rs,db,ready,done,busy}", cyc),
                  32'({lcd_en, lcd_rw, lcd_rs, lcd_db, cmd_ready, init_done, busy}),
                  32'({exp_now.en, 1'b0, exp_now.rs, exp_now.db, exp_now.ready, exp_now.done, ~exp_now.ready}));
        end
    end

    // Pulse monitor: records cycle, rs and db at every rising edge of lcd_en.
    int         rise_cyc[$];
    logic [7:0] rise_db[$];
    logic       rise_rs[$];
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lcd_en && !prev_en) begin
                rise_cyc.push_back(cyc);
                rise_db.push_back(lcd_db);
                rise_rs.push_back(lcd_rs);
            end
            prev_en = lcd_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic clear_pulses();
        rise_cyc.delete();
        rise_db.delete();
        rise_rs.delete();
    endtask

    task automatic wait_ready(input string name, output int rcyc);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready within budget"}, 32'(cmd_ready), 32'd1);
        rcyc = cyc;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit keep, output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept 0x%0h within budget", d), 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_init_replay(input string tag);
        int r;
        wait_ready(tag, r);
        check({tag, " cycles to ready"}, 32'(r), 32'd98);
        check({tag, " pulse count"}, 32'(rise_db.size()), 32'd6);
        for (int i = 0; i < 6 && i < rise_db.size(); i++) begin
            check($sformatf("%s init byte %0d", tag, i), 32'(rise_db[i]), 32'(init_seq[i]));
            check($sformatf("%s init rs %0d", tag, i), 32'(rise_rs[i]), 32'd0);
        end
        if (rise_cyc.size() == 6) begin
            check({tag, " first E rise cycle"}, 32'(rise_cyc[0]), 32'd13);
            check({tag, " rise spacing normal"}, 32'(rise_cyc[1] - rise_cyc[0]), 32'd12);
            check({tag, " rise spacing after clear"}, 32'(rise_cyc[5] - rise_cyc[4]), 32'd27);
        end
        check({tag, " init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, r, cnt;
        logic [7:0] seen;
        logic        vec_rs  [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0]  vec_db  [3] = '{8'h01, 8'h01, 8'h80};
        int          vec_lat [3] = '{27, 12, 12};
        logic [7:0]  b2b     [3] = '{8'h48, 8'h49, 8'h21};

        // 1: power-up wait and init sequence
        repeat (3) @(negedge clk);
        check("reset ready", 32'(cmd_ready), 32'd0);
        check("reset en", 32'(lcd_en), 32'd0);
        rst_n = 1'b1;
        check("model init schedule length", 32'(sched.size()), 32'd97);
        check_init_replay("init");

        // 2: single character
        clear_pulses();
        send(1'b1, 8'h41, 1'b0, acc);
        wait_ready("char", r);
        check("char latency", 32'(r - acc), 32'd12);
        check("char pulse count", 32'(rise_db.size()), 32'd1);
        if (rise_db.size() == 1) begin
            check("char db", 32'(rise_db[0]), 32'h41);
            check("char rs", 32'(rise_rs[0]), 32'd1);
        end

        // 3: execution wait selection
        for (int i = 0; i < 3; i++) begin
            send(vec_rs[i], vec_db[i], 1'b0, acc);
            wait_ready("wait sel", r);
            check($sformatf("latency rs=%0b db=0x%0h", vec_rs[i], vec_db[i]), 32'(r - acc), 32'(vec_lat[i]));
        end

        // 4: back-to-back with valid held high
        clear_pulses();
        for (int i = 0; i < 3; i++) send(1'b1, b2b[i], (i < 2), acc);
        wait_ready("b2b", r);
        check("b2b pulse count", 32'(rise_db.size()), 32'd3);
        for (int i = 0; i < 3 && i < rise_db.size(); i++)
            check($sformatf("b2b byte %0d", i), 32'(rise_db[i]), 32'(b2b[i]));

        // 5: reset during the second E-high cycle
        send(1'b1, 8'h5A, 1'b0, acc);
        cnt = 0;
        while (!lcd_en && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("E high before reset", 32'(lcd_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pins {en,rw,rs,db,ready,done,busy}",
              32'({lcd_en, lcd_rw, lcd_rs, lcd_db, cmd_ready, init_done, busy}), 32'b0_0_0_00000000_0_0_1);
        clear_pulses();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("model replay schedule length", 32'(sched.size()), 32'd97);
        check_init_replay("replay");

        // 6: instance without init sequence
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        check("noinit ready at release", 32'(ready2), 32'd0);
        @(posedge clk);
        #1;
        check("noinit ready after 1 cycle", 32'(ready2), 32'd1);
        check("noinit done after 1 cycle", 32'(done2), 32'd1);
        check("noinit busy", 32'(busy2), 32'd0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (en2) cnt++;
        end
        check("noinit E idle", 32'(cnt), 32'd0);
        valid2 = 1'b1;
        rs2    = 1'b1;
        data2  = 8'h55;
        @(posedge clk);
        #1 valid2 = 1'b0;
        cnt  = 0;
        seen = 8'h00;
        repeat (20) begin
            @(negedge clk);
            if (en2) begin
                cnt++;
                seen = db2;
            end
        end
        check("noinit E high cycles", 32'(cnt), 32'(EN_HIGH));
        check("noinit db", 32'(seen), 32'h55);
        check("noinit rs/rw", 32'({lcd_rs2, rw2}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
